// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared encodings, stage payloads and helpers for fp_addsub_pipe
package fp_pkg;

  // Default format: single precision significand (with hidden bit) and exponent
  localparam int FP_MW  = 24;
  localparam int FP_EW  = 8;
  localparam int FP_LZW = $clog2(FP_MW + 1);

  // Magnitude-compare codes from the exponent-align stage (2'b11 behaves as EQ)
  localparam logic [1:0] CMP_EQ  = 2'b00;
  localparam logic [1:0] CMP_AGT = 2'b01;
  localparam logic [1:0] CMP_BGT = 2'b10;

  // Stage 1 -> stage 2: combined significand (one carry bit wide), sign, exponent
  typedef struct packed {
    logic [FP_MW:0]   raw;
    logic             sign;
    logic [FP_EW-1:0] ea;
  } s1_t;

  // Stage 2 -> stage 3: adds carry, zero detect and leading-zero count
  typedef struct packed {
    logic [FP_MW:0]    raw;
    logic              carry;
    logic              is_zero;
    logic [FP_LZW-1:0] lz;
    logic              sign;
    logic [FP_EW-1:0]  ea;
  } s2_t;

  // All-ones exponent value (infinity encoding) for an ew-bit exponent
  function automatic logic [31:0] EXP_MAX(input int unsigned ew);
    return (32'd1 << ew) - 32'd1;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// rtl/fp_lzc.sv - combinational leading-zero counter
module fp_lzc
  import fp_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] data,
  output logic [CW-1:0]    count,
  output logic             all_zero
);

  // Scan upward so the highest set bit is the last to write the count
  always_comb begin
    count = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (data[i]) count = CW'(WIDTH - 1 - i);
    end
  end

  assign all_zero = ~|data;

endmodule

// File: rtl/fp_addsub_pipe.sv
// rtl/fp_addsub_pipe.sv - 3-stage elastic significand add/sub with normalisation
module fp_addsub_pipe
  import fp_pkg::*;
#(
  parameter int MW = FP_MW,
  parameter int EW = FP_EW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          sa,
  input  logic          sb,
  input  logic          op,
  input  logic [1:0]    cmp,
  input  logic [EW-1:0] ea,
  input  logic [MW-1:0] ma,
  input  logic [MW-1:0] mb,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          sign,
  output logic [EW-1:0] exp,
  output logic [MW-1:0] mant,
  output logic          zero,
  output logic          ovf,
  output logic          unf
);

  localparam int LZW = $clog2(MW + 1);

  logic v1, v2, v3;
  logic ld1, ld2, ld3;
  s1_t  s1_d, s1_q;
  s2_t  s2_d, s2_q;

  // A stage may load when empty or when the stage after it is moving on
  assign ld3      = !v3 || out_ready;
  assign ld2      = !v2 || ld3;
  assign ld1      = !v1 || ld2;
  assign in_ready = ld1;
  assign out_valid = v3;

  // Stage valid chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      if (ld1) v1 <= in_valid;
      if (ld2) v2 <= v1;
      if (ld3) v3 <= v2;
    end
  end

  // Stage 1: resolve effective operation, pick subtraction order and sign
  logic          eff_sub;
  logic [MW:0]   ma_x, mb_x;
  always_comb begin
    eff_sub = sa ^ sb ^ op;
    ma_x    = {1'b0, ma};
    mb_x    = {1'b0, mb};
    s1_d    = '0;
    s1_d.ea = ea;
    if (!eff_sub) begin
      s1_d.raw  = ma_x + mb_x;
      s1_d.sign = sa;
    end else begin
      case (cmp)
        CMP_AGT: begin
          s1_d.raw  = ma_x - mb_x;
          s1_d.sign = sa;
        end
        CMP_BGT: begin
          s1_d.raw  = mb_x - ma_x;
          s1_d.sign = sb ^ op;
        end
        default: begin
          // Equal magnitudes cancel exactly; result is +0
          s1_d.raw  = '0;
          s1_d.sign = 1'b0;
        end
      endcase
    end
  end

  // Stage 1 payload register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s1_q <= '0;
    else if (ld1 && in_valid) s1_q <= s1_d;
  end

  // Stage 2: carry-out, zero detect and leading-zero count of the low MW bits
  logic [LZW-1:0] lz;
  logic           low_zero;

  fp_lzc #(.WIDTH(MW), .CW(LZW)) u_lzc (
    .data     (s1_q.raw[MW-1:0]),
    .count    (lz),
    .all_zero (low_zero)
  );

  always_comb begin
    s2_d         = '0;
    s2_d.raw     = s1_q.raw;
    s2_d.carry   = s1_q.raw[MW];
    s2_d.is_zero = low_zero && !s1_q.raw[MW];
    s2_d.lz      = lz;
    s2_d.sign    = s1_q.sign;
    s2_d.ea      = s1_q.ea;
  end

  // Stage 2 payload register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s2_q <= '0;
    else if (ld2 && v1) s2_q <= s2_d;
  end

  // Stage 3: normalise and flag; exponent math carries one guard bit
  logic [EW:0]   ea_x, lz_x, exp_inc;
  logic [EW-1:0] exp_dec;
  logic          n_sign, n_zero, n_ovf, n_unf;
  logic [EW-1:0] n_exp;
  logic [MW-1:0] n_mant;
  always_comb begin
    ea_x    = {1'b0, s2_q.ea};
    lz_x    = (EW+1)'(s2_q.lz);
    exp_inc = ea_x + {{EW{1'b0}}, 1'b1};
    exp_dec = s2_q.ea - EW'(s2_q.lz);
    n_sign  = s2_q.sign;
    n_exp   = '0;
    n_mant  = '0;
    n_zero  = 1'b0;
    n_ovf   = 1'b0;
    n_unf   = 1'b0;
    if (s2_q.is_zero) begin
      n_sign = 1'b0;
      n_zero = 1'b1;
    end else if (s2_q.carry) begin
      if (exp_inc >= (EW+1)'(EXP_MAX(EW))) begin
        n_ovf = 1'b1;
        n_exp = '1;
      end else begin
        n_mant = s2_q.raw[MW:1];
        n_exp  = exp_inc[EW-1:0];
      end
    end else if (lz_x >= ea_x) begin
      // Normalising would drive the exponent to zero or below: flush
      n_unf  = 1'b1;
      n_zero = 1'b1;
    end else begin
      n_mant = s2_q.raw[MW-1:0] << s2_q.lz;
      n_exp  = exp_dec;
    end
  end

  // Stage 3 output register; holds while downstream stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign <= 1'b0;
      exp  <= '0;
      mant <= '0;
      zero <= 1'b0;
      ovf  <= 1'b0;
      unf  <= 1'b0;
    end else if (ld3 && v2) begin
      sign <= n_sign;
      exp  <= n_exp;
      mant <= n_mant;
      zero <= n_zero;
      ovf  <= n_ovf;
      unf  <= n_unf;
    end
  end

endmodule
